// File: rtl/onehot_drain.sv
// rtl/onehot_drain.sv - hot vector to ascending index stream; optional ONEHOT_DRAIN_STRICT_EN
module onehot_drain #(
  parameter int NR_KEY    = 2,
  parameter int KEY_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NR_KEY-1:0]    in_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [KEY_WIDTH-1:0] out_idx,
  output logic                 out_last,
  output logic                 busy,
  output logic                 err
);

  localparam int MIN_KW = (NR_KEY > 1) ? $clog2(NR_KEY) : 1;

  if (NR_KEY < 1) begin : g_bad_nr_key
    $error("onehot_drain: NR_KEY must be at least 1");
  end
  if (KEY_WIDTH < MIN_KW) begin : g_bad_key_width
    $error("onehot_drain: KEY_WIDTH too small for NR_KEY");
  end

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t                r_state;
  logic [NR_KEY-1:0]     r_mask;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [KEY_WIDTH-1:0]  r_out_idx;
  logic                  r_out_last;
  logic                  r_busy;

  logic [NR_KEY-1:0]     w_cap_mask;
  logic [NR_KEY-1:0]     w_rem_mask;
  logic [KEY_WIDTH-1:0]  w_cap_idx;
  logic                  w_cap_last;
  logic [KEY_WIDTH-1:0]  w_rem_idx;
  logic                  w_rem_last;

  // Position of the lowest set bit; zero for an empty vector.
  function automatic logic [KEY_WIDTH-1:0] lowest_idx(input logic [NR_KEY-1:0] v);
    logic [KEY_WIDTH-1:0] idx;
    idx = '0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (v[i]) idx = KEY_WIDTH'(i);
    end
    return idx;
  endfunction

  // True when exactly one bit is set.
  function automatic logic is_onehot(input logic [NR_KEY-1:0] v);
    return (v != '0) && ((v & (v - NR_KEY'(1))) == '0);
  endfunction

  // Next-beat decode for a fresh capture and for the mask after popping one bit.
  always_comb begin
`ifdef ONEHOT_DRAIN_STRICT_EN
    // Strict mode keeps only the lowest set bit of the captured vector.
    w_cap_mask = in_vec & (~in_vec + NR_KEY'(1));
`else
    w_cap_mask = in_vec;
`endif
    w_rem_mask = r_mask & (r_mask - NR_KEY'(1));
    w_cap_idx  = lowest_idx(w_cap_mask);
    w_cap_last = is_onehot(w_cap_mask);
    w_rem_idx  = lowest_idx(w_rem_mask);
    w_rem_last = is_onehot(w_rem_mask);
  end

`ifdef ONEHOT_DRAIN_STRICT_EN
  logic r_err;

  // Malformed-vector pulse: one cycle after any capture whose popcount is not one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == S_IDLE) && in_valid && ($countones(in_vec) != 1);
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  // Capture/drain FSM; every output is registered so no input reaches an output combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mask      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && (in_vec != '0)) begin
            r_state     <= S_DRAIN;
            r_mask      <= w_cap_mask;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
            r_out_idx   <= w_cap_idx;
            r_out_last  <= w_cap_last;
            r_busy      <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (r_out_last) begin
              r_state     <= S_IDLE;
              r_mask      <= '0;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
              r_out_idx   <= '0;
              r_out_last  <= 1'b0;
              r_busy      <= 1'b0;
            end else begin
              r_mask     <= w_rem_mask;
              r_out_idx  <= w_rem_idx;
              r_out_last <= w_rem_last;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;
  assign busy      = r_busy;

endmodule

// File: tb/tb_onehot_drain.sv
// tb/tb_onehot_drain.sv - randomized self-checking bench for onehot_drain
module tb_onehot_drain;

  localparam int NR_KEY    = 8;
  localparam int KEY_WIDTH = 3;
`ifdef ONEHOT_DRAIN_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [NR_KEY-1:0]    in_vec;
  logic                 out_valid;
  logic                 out_ready;
  logic [KEY_WIDTH-1:0] out_idx;
  logic                 out_last;
  logic                 busy;
  logic                 err;

  int n_tests = 0;
  int n_fail  = 0;

  // observed results of one transaction
  logic [31:0] obs_sig;
  int          obs_n;
  int          obs_err;
  int          obs_drain_cycles;
  int          obs_stall_viol;
  logic        obs_timeout;
  logic        obs_in_ready_after;

  // expected results from the reference model
  logic [31:0] exp_sig;
  int          exp_n;
  int          exp_err;

  onehot_drain #(.NR_KEY(NR_KEY), .KEY_WIDTH(KEY_WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: list of indices the vector should produce, packed as {last, idx} nibbles.
  function automatic void build_exp(input logic [NR_KEY-1:0] v);
    int q[$];
    int ones;
    ones = 0;
    for (int i = 0; i < NR_KEY; i++) if (v[i]) ones++;
    for (int i = 0; i < NR_KEY; i++) begin
      if (v[i]) begin
        q.push_back(i);
        if (STRICT) break;
      end
    end
    exp_n   = q.size();
    exp_sig = '0;
    for (int k = 0; k < q.size(); k++) begin
      exp_sig = (exp_sig << 4) | 32'(q[k]) | ((k == q.size() - 1) ? 32'h8 : 32'h0);
    end
    exp_err = (STRICT && ones != 1) ? 1 : 0;
  endfunction

  // Send one vector and drain it. mode 0: always ready, 1: fixed stall pattern, 2: random.
  task automatic collect(input logic [NR_KEY-1:0] vec, input int mode);
    int pat [6] = '{0, 1, 0, 0, 1, 1};
    int pc;
    int guard;
    logic prev_stall;
    logic [KEY_WIDTH:0] prev_beat;
    obs_sig = '0; obs_n = 0; obs_err = 0; obs_drain_cycles = 0;
    obs_stall_viol = 0; obs_timeout = 1'b0; pc = 0; prev_stall = 1'b0; prev_beat = '0;
    @(negedge clk);
    out_ready = 1'b0;
    in_vec    = vec;
    in_valid  = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) obs_timeout = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_vec   = NR_KEY'($urandom);
    guard = 0;
    forever begin
      @(negedge clk);
      if (err) obs_err++;
      if (!out_valid) break;
      guard++;
      if (guard > 200) begin
        obs_timeout = 1'b1;
        break;
      end
      obs_drain_cycles++;
      if (prev_stall && ({out_last, out_idx} != prev_beat)) obs_stall_viol++;
      if (mode == 0)      out_ready = 1'b1;
      else if (mode == 1) out_ready = pat[pc % 6] != 0;
      else                out_ready = $urandom_range(0, 1) != 0;
      pc++;
      if (mode != 0) begin
        in_valid = $urandom_range(0, 1) != 0;
        in_vec   = NR_KEY'($urandom);
      end
      if (out_ready) begin
        obs_sig = (obs_sig << 4) | {28'd0, out_last, out_idx};
        obs_n++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
        prev_beat  = {out_last, out_idx};
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    obs_in_ready_after = in_ready;
    @(negedge clk);
    if (err) obs_err++;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({in_ready, out_valid, out_idx, out_last, busy, err} !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b want=%b", {in_ready, out_valid, out_idx, out_last, busy, err}, 8'b1000_0000);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    build_exp(8'b0000_0100);
    collect(8'b0000_0100, 0);
    n_tests++;
    if (obs_sig !== 32'h0000_000A || obs_n != 1) begin
      n_fail++;
      $display("FAIL single_beat got=%h n=%0d want=%h n=1", obs_sig, obs_n, 32'h0000_000A);
    end
    n_tests++;
    if (obs_in_ready_after !== 1'b1) begin
      n_fail++;
      $display("FAIL single_in_ready_return got=%b want=1", obs_in_ready_after);
    end
    n_tests++;
    if (obs_err != 0) begin
      n_fail++;
      $display("FAIL single_err got=%0d want=0", obs_err);
    end
  endtask

  task automatic test_multi();
    build_exp(8'b1001_0010);
    collect(8'b1001_0010, 0);
    n_tests++;
    if (obs_sig !== exp_sig || obs_n != exp_n) begin
      n_fail++;
      $display("FAIL multi_sequence got=%h n=%0d want=%h n=%0d", obs_sig, obs_n, exp_sig, exp_n);
    end
    n_tests++;
    if (obs_drain_cycles != exp_n) begin
      n_fail++;
      $display("FAIL multi_throughput got=%0d cycles want=%0d", obs_drain_cycles, exp_n);
    end
    n_tests++;
    if (obs_err != exp_err) begin
      n_fail++;
      $display("FAIL multi_err got=%0d want=%0d", obs_err, exp_err);
    end
  endtask

  task automatic test_stall();
    build_exp(8'b1001_0010);
    collect(8'b1001_0010, 1);
    n_tests++;
    if (obs_sig !== exp_sig || obs_n != exp_n) begin
      n_fail++;
      $display("FAIL stall_sequence got=%h n=%0d want=%h n=%0d", obs_sig, obs_n, exp_sig, exp_n);
    end
    n_tests++;
    if (obs_stall_viol != 0 || obs_timeout) begin
      n_fail++;
      $display("FAIL stall_hold got=%0d changes timeout=%b want=0 changes", obs_stall_viol, obs_timeout);
    end
  endtask

  task automatic test_zero();
    build_exp(8'b0000_0000);
    collect(8'b0000_0000, 0);
    n_tests++;
    if (obs_n != 0 || obs_drain_cycles != 0) begin
      n_fail++;
      $display("FAIL zero_no_beats got=%0d beats %0d cycles want=0", obs_n, obs_drain_cycles);
    end
    n_tests++;
    if (obs_in_ready_after !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_idle got in_ready=%b busy=%b want in_ready=1 busy=0", obs_in_ready_after, busy);
    end
    n_tests++;
    if (obs_err != exp_err) begin
      n_fail++;
      $display("FAIL zero_err got=%0d want=%0d", obs_err, exp_err);
    end
  endtask

  task automatic test_two_hot();
    build_exp(8'b1000_0001);
    collect(8'b1000_0001, 0);
    n_tests++;
    if (obs_sig !== exp_sig || obs_n != exp_n) begin
      n_fail++;
      $display("FAIL two_hot_sequence got=%h n=%0d want=%h n=%0d", obs_sig, obs_n, exp_sig, exp_n);
    end
    n_tests++;
    if (obs_err != exp_err) begin
      n_fail++;
      $display("FAIL two_hot_err got=%0d want=%0d", obs_err, exp_err);
    end
  endtask

  task automatic test_reset_mid_drain();
    int beats;
    int guard;
    @(negedge clk);
    in_vec = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    beats = 0;
    guard = 0;
    while (beats < 3 && guard < 20) begin
      @(posedge clk);
      guard++;
      if (out_valid) beats++;
    end
    #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({in_ready, out_valid, out_idx, out_last, busy, err} !== 8'b1000_0000 || beats != 3) begin
      n_fail++;
      $display("FAIL reset_mid_drain got=%b beats=%0d want=%b beats=3", {in_ready, out_valid, out_idx, out_last, busy, err}, beats, 8'b1000_0000);
    end
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    build_exp(8'b0010_0000);
    collect(8'b0010_0000, 0);
    n_tests++;
    if (obs_sig !== 32'h0000_000D || obs_n != 1) begin
      n_fail++;
      $display("FAIL after_reset_vector got=%h n=%0d want=%h n=1", obs_sig, obs_n, 32'h0000_000D);
    end
  endtask

  task automatic test_random();
    logic [NR_KEY-1:0] v;
    for (int t = 0; t < 40; t++) begin
      v = NR_KEY'($urandom);
      if (t % 9 == 0) v = '0;
      build_exp(v);
      collect(v, 2);
      n_tests++;
      if (obs_sig !== exp_sig || obs_n != exp_n || obs_timeout) begin
        n_fail++;
        $display("FAIL random_seq vec=%b got=%h n=%0d want=%h n=%0d", v, obs_sig, obs_n, exp_sig, exp_n);
      end
      n_tests++;
      if (obs_err != exp_err || obs_stall_viol != 0) begin
        n_fail++;
        $display("FAIL random_err_hold vec=%b got err=%0d changes=%0d want err=%0d changes=0", v, obs_err, obs_stall_viol, exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_stall();
    test_zero();
    test_two_hot();
    test_reset_mid_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/onehot_drain.md
# onehot_drain

Sequential one-hot/multi-hot to index decoder, the inverse of the key-to-one-hot selector used in the datapath mux layer. It accepts a hot vector over a valid/ready handshake and emits the index of every set bit, lowest first, one per cycle over a second valid/ready handshake. Downstream logic uses it to turn select or grant masks back into key indices for table lookups and write-back steering.

## Interface

- `NR_KEY`, default 2: vector width, i.e. number of keys; must be ≥ 1.
- `KEY_WIDTH`, default 1: index width. Must satisfy KEY_WIDTH ≥ max(1, $clog2(NR_KEY)). Violation is an elaboration-time `$error`.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in_vec` is valid.
- `in_ready`  out  1  block can capture a vector.
- `in_vec`  in  NR_KEY  hot vector; bit i means key i.
- `out_valid`  out  1  `out_idx` is valid.
- `out_ready`  in  1  consumer accepts `out_idx`.
- `out_idx`  out  KEY_WIDTH  index of the lowest remaining set bit, zero-extended.
- `out_last`  out  1  current beat is the final index of this vector.
- `busy`  out  1  high while in DRAIN.
- `err`  out  1  one-cycle malformed-vector pulse; constant 0 unless the macro is defined.

## Operation

- State is `mask[NR_KEY]` plus a two-state FSM: IDLE and DRAIN.
- **IDLE:** `in_ready`=1 and `out_valid`=0.
  - On `in_valid && in_ready` with nonzero `in_vec`: `mask` ← `in_vec`, go to DRAIN.
  - With `in_vec`==0: vector is consumed and dropped, stay in IDLE.
- **DRAIN:** `in_ready`=0 and `out_valid`=1.
  - `out_idx` = position of the lowest set bit of `mask`.
  - `out_last` = (`mask` has exactly one bit set).
  - On `out_valid && out_ready`: clear that bit in `mask`. If `out_last`, go to IDLE with `mask` ← 0.
  - With `out_ready`=0: `out_idx` and `out_last` hold stable and `mask` is unchanged.
- `out_idx`, `out_last`, `out_valid`, `in_ready` and `busy` are decoded from registers only. No combinational path from any input to any output.
- Index arithmetic: bit i produces the value i in KEY_WIDTH bits. Bit NR_KEY-1 is the highest emitted index. No wrap-around.
- Order is strictly ascending index within a vector. Vectors never interleave.

## Timing

- Reset values: FSM=IDLE, `mask`=0, `in_ready`=1, `out_valid`=0, `out_idx`=0, `out_last`=0, `busy`=0, `err`=0.
- Latency: vector captured at edge N gives its first `out_valid` in cycle N+1.
- Throughput: with `out_ready` held high, one index per cycle. A vector with k set bits occupies k DRAIN cycles.
- Turnaround: last handshake at edge M gives IDLE in cycle M+1; `in_ready`=1 in cycle M+1; the next vector can be captured at M+1 and its first beat appears in M+2.
- `in_valid` during DRAIN is ignored; the producer must hold the vector until `in_ready`.
- Reset asserted mid-DRAIN: immediately (asynchronously) returns all state and outputs to reset values. Remaining indices are discarded.

## Configuration

- Macro: `ONEHOT_DRAIN_STRICT_EN`.
- Defined (strict one-hot mode):
  - At capture, popcount(`in_vec`) ≠ 1 (including zero) raises `err` for exactly the cycle after the capturing edge.
  - A multi-hot vector drains only its lowest set bit, as a single beat with `out_last`=1.
  - A zero vector is still dropped.
- Undefined:
  - `err` is tied to 0.
  - Every set bit is drained.
  - A zero vector is dropped silently.

## Test plan

Bench uses NR_KEY=8, KEY_WIDTH=3.

- Reset, then `in_vec`=8'b0000_0100 with `out_ready`=1: one beat, `out_idx`=2, `out_last`=1. `in_ready` returns to 1 on the following cycle.
- `in_vec`=8'b1001_0010 with `out_ready`=1, macro off: beats `out_idx`=1, 4, 7 on consecutive cycles; `out_last` only on 7; `err`=0 throughout.
- Same vector with `out_ready` toggling 0,1,0,0,1,1: `out_idx` holds during stalls and the sequence stays 1, 4, 7. `in_vec` changes while `in_ready`=0 are ignored.
- `in_vec`=0: no `out_valid`, FSM stays in IDLE, `in_ready` stays 1. With the macro on, `err` pulses for 1 cycle.
- With the macro on, `in_vec`=8'b1000_0001: single beat `out_idx`=0, `out_last`=1, and `err`=1 for one cycle after capture.
- `in_vec`=8'hFF, assert `rst` after the 3rd beat: outputs immediately return to reset values. The next vector 8'b0010_0000 yields only `out_idx`=5.
